burst_memory_interface: RTL and testbench
=========================================

BURST_MEMORY_INTERFACE -- requirements
Module: burst_memory_interface

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the data word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 19, giving the word address width.
REQ-003 SHALL have parameter BURST_W, default 4, giving the burstcount width.
REQ-004 SHALL have parameter RD_LAT, default 2, giving the SRAM read latency in cycles (legal 1..4).
REQ-005 SHALL have one clock, clock (input, 1 bit); reset is asynchronous and active-low, reset_n (input, 1 bit).
REQ-006 SHALL have avmm_data_addr (in, ADDR_W), avmm_data_read (in, 1) and avmm_data_write (in, 1).
REQ-007 SHALL have avmm_data_writedata (in, DATA_W) and avmm_data_byteenable (in, DATA_W/8).
REQ-008 SHALL have avmm_data_burstcount (in, BURST_W), avmm_data_readdata (out, DATA_W), avmm_data_waitrequest (out, 1) and avmm_data_readdatavalid (out, 1).
REQ-009 SHALL have avmm_csr_addr (in, 2), avmm_csr_read (in, 1), avmm_csr_write (in, 1), avmm_csr_writedata (in, 32) and avmm_csr_readdata (out, 32).
REQ-010 SHALL have mem_addr (out, ADDR_W), mem_re (out, 1), mem_we (out, 1), mem_be (out, DATA_W/8), mem_wdata (out, DATA_W) and mem_rdata (in, DATA_W); the SRAM returns data RD_LAT cycles after mem_re.

Function
REQ-011 SHALL implement FSM states IDLE, RD_BURST and WR_BURST.
REQ-012 avmm_data_waitrequest SHALL equal (state != IDLE) OR (CTRL.enable == 0), except in WR_BURST, where it SHALL be low.
REQ-013 On a read accepted at cycle T (read=1, waitrequest=0) with burstcount N, the block SHALL issue mem_re at T+1..T+N with addresses A, A+1, ... modulo 2^ADDR_W, then return to IDLE.
REQ-014 avmm_data_readdatavalid SHALL pulse for each beat exactly RD_LAT cycles after its mem_re, in order, with readdata = mem_rdata; readdata is don't-care otherwise.
REQ-015 A new command SHALL be accepted while earlier read beats are still returning; read data order SHALL be preserved.
REQ-016 On a write accepted at T with burstcount N, beat 0 SHALL be written at T+1; the FSM SHALL enter WR_BURST until N beats are accepted; each beat SHALL be written one cycle after acceptance, with the address incrementing and wrapping as in REQ-013.
REQ-017 Within WR_BURST, cycles with write=0 SHALL be stalls with no memory access.
REQ-018 A read asserted in WR_BURST SHALL be ignored and SHALL set STATUS.err.
REQ-019 burstcount 0 SHALL be accepted, SHALL perform no access, and SHALL set STATUS.err.
REQ-020 Simultaneous read and write in IDLE SHALL perform the read only and SHALL set STATUS.err.
REQ-021 CSR map: 0 CTRL (bit0 enable, R/W); 1 STATUS (bit0 busy = state != IDLE OR read beats outstanding; bit1 err, sticky, write-1-to-clear); 2 RDBEATS; 3 WRBEATS.
REQ-022 RDBEATS and WRBEATS SHALL be 32-bit counters of completed beats that wrap at 2^32; any CSR write to them SHALL clear them, with the clear winning over a same-cycle increment.
REQ-023 avmm_csr_readdata SHALL be registered, valid the cycle after avmm_csr_read, and held otherwise.
REQ-024 Clearing CTRL.enable mid-burst SHALL let the burst complete; new commands SHALL be blocked only from the next IDLE.

Reset
REQ-025 While reset_n is low: state = IDLE, enable = 1, err = 0, counters = 0, outstanding read pipeline flushed, and all outputs driven to 0 except avmm_data_waitrequest = 1.
REQ-026 After reset release, avmm_data_waitrequest SHALL fall on the first clock edge.
REQ-027 A reset during a burst SHALL abandon it; no readdatavalid SHALL appear for pre-reset beats.

Structure
REQ-028 FSM state encoding and CSR address constants SHALL live in a shared package, memory_interface_pkg.
REQ-029 The RD_LAT-deep valid shift register SHALL be a sub-module, rd_valid_pipe.

Verification
REQ-030 Read burst: A=0x10, N=4, RD_LAT=2, memory[k]=k -> readdatavalid at T+3..T+6 with data 0x10..0x13; RDBEATS=4.
REQ-031 Wrap: write burst at A=0x7FFFE, N=4 -> writes to 0x7FFFE, 0x7FFFF, 0x00000, 0x00001; WRBEATS=4.
REQ-032 Write stall: N=3 with write low for 2 cycles between beats 1 and 2 -> exactly 3 mem_we pulses, byteenable passed through unchanged.
REQ-033 Errors: burstcount 0, then read during WR_BURST -> no access, STATUS=0x2; CSR write 0x2 to STATUS -> STATUS=0x0.
REQ-034 Reset mid-read: reset_n low at beat 2 of N=8 -> no readdatavalid afterwards; waitrequest=1 during reset and 0 one cycle after release.
REQ-035 Back-to-back: read N=2 immediately followed by write N=1 -> write accepted while data drains; read data is unaffected and in order.

Source files
------------

// File: rtl/memory_interface_pkg.sv
// Shared FSM state encoding and CSR register map for the burst memory interface.
package memory_interface_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRdBurst = 2'd1,
    StWrBurst = 2'd2
  } state_e;

  localparam logic [1:0] CsrCtrl    = 2'd0;
  localparam logic [1:0] CsrStatus  = 2'd1;
  localparam logic [1:0] CsrRdBeats = 2'd2;
  localparam logic [1:0] CsrWrBeats = 2'd3;

endpackage

// File: rtl/burst_memory_interface_if.sv
// Avalon-MM burst data port between a bus master and the burst memory interface.
interface burst_memory_interface_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned BURST_W = 4
);
  logic [ADDR_W-1:0]   addr;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [BURST_W-1:0]  burstcount;
  logic [DATA_W-1:0]   readdata;
  logic                waitrequest;
  logic                readdatavalid;

  modport master (
    output addr, read, write, writedata, byteenable, burstcount,
    input  readdata, waitrequest, readdatavalid
  );

  modport slave (
    input  addr, read, write, writedata, byteenable, burstcount,
    output readdata, waitrequest, readdatavalid
  );
endinterface

// File: rtl/rd_valid_pipe.sv
// Shift register tracking issued read beats until their SRAM data returns.
module rd_valid_pipe #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic valid_o,
  output logic pending_o
);
  logic [Depth-1:0] pipe_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= valid_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign valid_o   = pipe_q[Depth-1];
  assign pending_o = |pipe_q;
endmodule

// File: rtl/burst_memory_interface.sv
// Avalon-MM burst slave in front of a fixed-latency synchronous SRAM, with a small CSR block.
module burst_memory_interface
  import memory_interface_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned BURST_W = 4,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  burst_memory_interface_if.slave avmm_data,
  input  logic [1:0]          avmm_csr_addr,
  input  logic                avmm_csr_read,
  input  logic                avmm_csr_write,
  input  logic [31:0]         avmm_csr_writedata,
  output logic [31:0]         avmm_csr_readdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  state_e              state_q;
  logic                live_q;
  logic                enable_q;
  logic                err_q;
  logic [31:0]         rdbeats_q;
  logic [31:0]         wrbeats_q;
  logic [31:0]         csr_rdata_q;
  logic [BURST_W-1:0]  cnt_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_re_q;
  logic                mem_we_q;
  logic [DATA_W/8-1:0] mem_be_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic        rd_valid;
  logic        rd_pending;
  logic        cmd_ok;
  logic        bc_zero;
  logic        busy;
  logic        err_set;
  logic        err_clr;
  logic [31:0] csr_mux;
  logic        unused_csr_wdata;

  // live_q holds waitrequest high until the first edge after reset release.
  assign cmd_ok  = (state_q == StIdle) && live_q && enable_q;
  assign bc_zero = (avmm_data.burstcount == '0);
  assign busy    = (state_q != StIdle) || mem_re_q || rd_pending;

  assign avmm_data.waitrequest   = !live_q || (state_q == StRdBurst) ||
                                   ((state_q == StIdle) && !enable_q);
  assign avmm_data.readdatavalid = rd_valid;
  assign avmm_data.readdata      = rd_valid ? mem_rdata : '0;

  assign mem_addr          = mem_addr_q;
  assign mem_re            = mem_re_q;
  assign mem_we            = mem_we_q;
  assign mem_be            = mem_be_q;
  assign mem_wdata         = mem_wdata_q;
  assign avmm_csr_readdata = csr_rdata_q;
  assign unused_csr_wdata  = ^avmm_csr_writedata[31:2];

  rd_valid_pipe #(
    .Depth(RD_LAT)
  ) u_rd_valid_pipe (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .valid_i  (mem_re_q),
    .valid_o  (rd_valid),
    .pending_o(rd_pending)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      live_q      <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      live_q   <= 1'b1;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Read has priority over a simultaneous write; burstcount 0 accesses nothing.
          if (cmd_ok && avmm_data.read && !bc_zero) begin
            mem_re_q   <= 1'b1;
            mem_addr_q <= avmm_data.addr;
            cnt_q      <= avmm_data.burstcount - BURST_W'(1);
            if (avmm_data.burstcount != BURST_W'(1)) state_q <= StRdBurst;
          end else if (cmd_ok && avmm_data.write && !avmm_data.read && !bc_zero) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= avmm_data.addr;
            mem_be_q    <= avmm_data.byteenable;
            mem_wdata_q <= avmm_data.writedata;
            cnt_q       <= avmm_data.burstcount - BURST_W'(1);
            if (avmm_data.burstcount != BURST_W'(1)) state_q <= StWrBurst;
          end
        end
        StRdBurst: begin
          mem_re_q   <= 1'b1;
          mem_addr_q <= mem_addr_q + ADDR_W'(1);
          cnt_q      <= cnt_q - BURST_W'(1);
          if (cnt_q == BURST_W'(1)) state_q <= StIdle;
        end
        StWrBurst: begin
          if (avmm_data.write) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_be_q    <= avmm_data.byteenable;
            mem_wdata_q <= avmm_data.writedata;
            cnt_q       <= cnt_q - BURST_W'(1);
            if (cnt_q == BURST_W'(1)) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    err_set = 1'b0;
    if (cmd_ok && (avmm_data.read || avmm_data.write)) begin
      err_set = bc_zero || (avmm_data.read && avmm_data.write);
    end
    if ((state_q == StWrBurst) && avmm_data.read) err_set = 1'b1;
    err_clr = avmm_csr_write && (avmm_csr_addr == CsrStatus) && avmm_csr_writedata[1];
  end

  always_comb begin
    csr_mux = '0;
    unique case (avmm_csr_addr)
      CsrCtrl:    csr_mux = {31'd0, enable_q};
      CsrStatus:  csr_mux = {30'd0, err_q, busy};
      CsrRdBeats: csr_mux = rdbeats_q;
      CsrWrBeats: csr_mux = wrbeats_q;
      default:    csr_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enable_q    <= 1'b1;
      err_q       <= 1'b0;
      rdbeats_q   <= '0;
      wrbeats_q   <= '0;
      csr_rdata_q <= '0;
    end else begin
      if (avmm_csr_write && (avmm_csr_addr == CsrCtrl)) enable_q <= avmm_csr_writedata[0];
      // A new error in the same cycle as the clear stays visible.
      err_q <= err_set || (err_q && !err_clr);
      if (avmm_csr_write && (avmm_csr_addr == CsrRdBeats)) rdbeats_q <= '0;
      else if (rd_valid)                                   rdbeats_q <= rdbeats_q + 32'd1;
      if (avmm_csr_write && (avmm_csr_addr == CsrWrBeats)) wrbeats_q <= '0;
      else if (mem_we_q)                                   wrbeats_q <= wrbeats_q + 32'd1;
      if (avmm_csr_read) csr_rdata_q <= csr_mux;
    end
  end
endmodule

// File: tb/tb_burst_memory_interface.sv
// Directed self-checking bench for burst_memory_interface with a 2-cycle SRAM model.
module tb_burst_memory_interface;
  import memory_interface_pkg::*;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned BURST_W = 4;
  localparam int unsigned RD_LAT  = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  burst_memory_interface_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

  logic [1:0]        csr_addr;
  logic              csr_read, csr_write;
  logic [31:0]       csr_wdata, csr_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re, mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata, mem_rdata;

  burst_memory_interface #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .RD_LAT(RD_LAT)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .avmm_data          (bus),
    .avmm_csr_addr      (csr_addr),
    .avmm_csr_read      (csr_read),
    .avmm_csr_write     (csr_write),
    .avmm_csr_writedata (csr_wdata),
    .avmm_csr_readdata  (csr_rdata),
    .mem_addr           (mem_addr),
    .mem_re             (mem_re),
    .mem_we             (mem_we),
    .mem_be             (mem_be),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata)
  );

  // SRAM model: unwritten word k reads as k, data returns two cycles after mem_re.
  logic [31:0] mem_store [int unsigned];
  logic [31:0] rd_s1, rd_s2;

  function automatic logic [31:0] sram_read(input logic [ADDR_W-1:0] a);
    if (mem_store.exists(32'(a))) return mem_store[32'(a)];
    return 32'(a);
  endfunction

  function automatic void sram_write(input logic [ADDR_W-1:0] a, input logic [3:0] be,
                                     input logic [31:0] d);
    logic [31:0] w;
    w = sram_read(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_store[32'(a)] = w;
  endfunction

  always @(posedge clock) begin
    rd_s1 <= mem_re ? sram_read(mem_addr) : 32'hxxxx_xxxx;
    rd_s2 <= rd_s1;
    if (mem_we) sram_write(mem_addr, mem_be, mem_wdata);
  end
  assign mem_rdata = rd_s2;

  typedef struct { int unsigned cyc; logic [31:0] data; } rdv_t;
  typedef struct { logic [ADDR_W-1:0] a; logic [3:0] be; logic [31:0] d; } wr_t;
  rdv_t              rdv_log[$];
  wr_t               wr_log[$];
  logic [ADDR_W-1:0] re_log[$];
  int unsigned       cyc = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.readdatavalid) rdv_log.push_back('{cyc: cyc, data: bus.readdata});
    if (mem_re) re_log.push_back(mem_addr);
    if (mem_we) wr_log.push_back('{a: mem_addr, be: mem_be, d: mem_wdata});
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic csr_access(input logic wr, input logic [1:0] a, input logic [31:0] d,
                            output logic [31:0] q);
    csr_addr = a; csr_read = !wr; csr_write = wr; csr_wdata = d;
    tick();
    csr_read = 1'b0; csr_write = 1'b0;
    q = csr_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] q;
    repeat (3) tick();
    n_checks++;
    if (bus.waitrequest !== 1'b1 || bus.readdatavalid !== 1'b0 || mem_re !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== '0 || csr_rdata !== 32'd0 || bus.readdata !== '0)
      $display("FAIL reset_outputs: wr=%b rdv=%b re=%b we=%b addr=%h csr=%h, want 1,0,0,0,0,0",
               bus.waitrequest, bus.readdatavalid, mem_re, mem_we, mem_addr, csr_rdata);
    else n_pass++;
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (bus.waitrequest !== 1'b1) $display("FAIL release_wait_hi: got %b want 1", bus.waitrequest);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.waitrequest !== 1'b0) $display("FAIL release_wait_lo: got %b want 0", bus.waitrequest);
    else n_pass++;
    csr_access(1'b0, CsrCtrl, 32'd0, q);
    n_checks++;
    if (q !== 32'd1) $display("FAIL reset_ctrl: got %h want 1", q); else n_pass++;
    csr_access(1'b0, CsrStatus, 32'd0, q);
    n_checks++;
    if (q !== 32'd0) $display("FAIL reset_status: got %h want 0", q); else n_pass++;
  endtask

  task automatic test_read_burst();
    logic [31:0] q;
    int unsigned t0;
    rdv_log.delete(); re_log.delete();
    bus.addr = 19'h10; bus.burstcount = 4'd4; bus.read = 1'b1;
    tick();
    t0 = cyc - 1;
    bus.read = 1'b0;
    n_checks++;
    if (bus.waitrequest !== 1'b1) $display("FAIL rd_busy_wait: got %b want 1", bus.waitrequest);
    else n_pass++;
    repeat (8) tick();
    n_checks++;
    if (rdv_log.size() != 4) $display("FAIL rd_beats: got %0d want 4", rdv_log.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rdv_t e = (i < rdv_log.size()) ? rdv_log[i] : '{cyc: 0, data: '0};
      n_checks++;
      if (e.cyc !== t0 + 3 + i || e.data !== 32'h10 + i)
        $display("FAIL rd_beat%0d: got cyc T+%0d data %h want T+%0d data %h",
                 i, e.cyc - t0, e.data, 3 + i, 32'h10 + i);
      else n_pass++;
    end
    n_checks++;
    if (re_log.size() != 4 || re_log[3] !== 19'h13)
      $display("FAIL rd_mem_re: got %0d pulses want 4 ending at 0x13", re_log.size());
    else n_pass++;
    csr_access(1'b0, CsrRdBeats, 32'd0, q);
    n_checks++;
    if (q !== 32'd4) $display("FAIL rdbeats: got %0d want 4", q); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0]       q;
    logic [ADDR_W-1:0] exp_a [4];
    exp_a = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
    wr_log.delete();
    bus.addr = 19'h7FFFE; bus.burstcount = 4'd4; bus.byteenable = 4'hF; bus.write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.writedata = 32'hA0 + i;
      tick();
    end
    bus.write = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (wr_log.size() != 4) $display("FAIL wrap_count: got %0d want 4", wr_log.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      wr_t e = (i < wr_log.size()) ? wr_log[i] : '{a: '0, be: '0, d: '0};
      n_checks++;
      if (e.a !== exp_a[i] || e.d !== 32'hA0 + i)
        $display("FAIL wrap_beat%0d: got addr %h data %h want addr %h data %h",
                 i, e.a, e.d, exp_a[i], 32'hA0 + i);
      else n_pass++;
    end
    csr_access(1'b0, CsrWrBeats, 32'd0, q);
    n_checks++;
    if (q !== 32'd4) $display("FAIL wrbeats: got %0d want 4", q); else n_pass++;
  endtask

  task automatic test_write_stall();
    wr_log.delete();
    bus.addr = 19'h100; bus.burstcount = 4'd3; bus.byteenable = 4'h5;
    bus.write = 1'b1; bus.writedata = 32'hB0; tick();
    bus.writedata = 32'hB1; tick();
    bus.write = 1'b0; repeat (2) tick();
    bus.write = 1'b1; bus.writedata = 32'hB2; tick();
    bus.write = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (wr_log.size() != 3) $display("FAIL stall_we_count: got %0d want 3", wr_log.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      wr_t e = (i < wr_log.size()) ? wr_log[i] : '{a: '0, be: '0, d: '0};
      n_checks++;
      if (e.a !== 19'h100 + i || e.be !== 4'h5 || e.d !== 32'hB0 + i)
        $display("FAIL stall_beat%0d: got addr %h be %h data %h want addr %h be 5 data %h",
                 i, e.a, e.be, e.d, 19'h100 + i, 32'hB0 + i);
      else n_pass++;
    end
  endtask

  task automatic test_errors();
    logic [31:0] q;
    re_log.delete(); wr_log.delete();
    bus.addr = 19'h20; bus.burstcount = 4'd0; bus.read = 1'b1; tick();
    bus.read = 1'b0; repeat (4) tick();
    csr_access(1'b0, CsrStatus, 32'd0, q);
    n_checks++;
    if (re_log.size() != 0 || q !== 32'h2)
      $display("FAIL err_bc0: got %0d reads status %h want 0 reads status 2", re_log.size(), q);
    else n_pass++;
    csr_access(1'b1, CsrStatus, 32'h2, q);
    csr_access(1'b0, CsrStatus, 32'd0, q);
    n_checks++;
    if (q !== 32'h0) $display("FAIL err_clear1: got %h want 0", q); else n_pass++;
    bus.addr = 19'h200; bus.burstcount = 4'd2; bus.byteenable = 4'hF;
    bus.write = 1'b1; bus.writedata = 32'hC0; tick();
    bus.write = 1'b0; bus.read = 1'b1; tick();
    bus.read = 1'b0; bus.write = 1'b1; bus.writedata = 32'hC1; tick();
    bus.write = 1'b0; repeat (3) tick();
    csr_access(1'b0, CsrStatus, 32'd0, q);
    n_checks++;
    if (re_log.size() != 0 || wr_log.size() != 2 || q !== 32'h2)
      $display("FAIL err_rd_in_wr: got %0d reads %0d writes status %h want 0,2,2",
               re_log.size(), wr_log.size(), q);
    else n_pass++;
    csr_access(1'b1, CsrStatus, 32'h2, q);
    bus.addr = 19'h30; bus.burstcount = 4'd1; bus.read = 1'b1; bus.write = 1'b1; tick();
    bus.read = 1'b0; bus.write = 1'b0; repeat (4) tick();
    csr_access(1'b0, CsrStatus, 32'd0, q);
    n_checks++;
    if (re_log.size() != 1 || re_log[0] !== 19'h30 || wr_log.size() != 2 || q !== 32'h2)
      $display("FAIL err_rd_wr: got %0d reads %0d writes status %h want 1,2,2",
               re_log.size(), wr_log.size(), q);
    else n_pass++;
    csr_access(1'b1, CsrStatus, 32'h2, q);
    csr_access(1'b1, CsrCtrl, 32'h0, q);
    n_checks++;
    if (bus.waitrequest !== 1'b1) $display("FAIL disable_wait: got %b want 1", bus.waitrequest);
    else n_pass++;
    bus.addr = 19'h40; bus.read = 1'b1; repeat (2) tick();
    bus.read = 1'b0; tick();
    n_checks++;
    if (re_log.size() != 1) $display("FAIL disable_block: got %0d reads want 1", re_log.size());
    else n_pass++;
    csr_access(1'b1, CsrCtrl, 32'h1, q);
    n_checks++;
    if (bus.waitrequest !== 1'b0) $display("FAIL enable_wait: got %b want 0", bus.waitrequest);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] q;
    bus.addr = 19'h40; bus.burstcount = 4'd8; bus.read = 1'b1; tick();
    bus.read = 1'b0; repeat (2) tick();
    reset_n = 1'b0;
    #1;
    rdv_log.delete();
    n_checks++;
    if (bus.waitrequest !== 1'b1 || bus.readdatavalid !== 1'b0 || mem_re !== 1'b0)
      $display("FAIL midrst_outputs: wr=%b rdv=%b re=%b want 1,0,0",
               bus.waitrequest, bus.readdatavalid, mem_re);
    else n_pass++;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (bus.waitrequest !== 1'b0) $display("FAIL midrst_release: got %b want 0", bus.waitrequest);
    else n_pass++;
    repeat (12) tick();
    n_checks++;
    if (rdv_log.size() != 0) $display("FAIL midrst_rdv: got %0d beats want 0", rdv_log.size());
    else n_pass++;
    csr_access(1'b0, CsrRdBeats, 32'd0, q);
    n_checks++;
    if (q !== 32'd0) $display("FAIL midrst_rdbeats: got %0d want 0", q); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q;
    int unsigned t0, tw;
    logic        acc_now, accepted;
    rdv_log.delete(); wr_log.delete();
    tw = 0; accepted = 1'b0;
    bus.addr = 19'h50; bus.burstcount = 4'd2; bus.read = 1'b1; tick();
    t0 = cyc - 1;
    bus.read = 1'b0; bus.write = 1'b1; bus.addr = 19'h60; bus.burstcount = 4'd1;
    bus.writedata = 32'hBEEF; bus.byteenable = 4'hF;
    for (int i = 0; i < 8 && !accepted; i++) begin
      acc_now = !bus.waitrequest;
      tick();
      if (acc_now) begin accepted = 1'b1; tw = cyc - 1; end
    end
    bus.write = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (!accepted || tw != t0 + 2)
      $display("FAIL b2b_accept: got accepted=%b at T+%0d want accepted at T+2", accepted, tw - t0);
    else n_pass++;
    n_checks++;
    if (rdv_log.size() != 2) $display("FAIL b2b_beats: got %0d want 2", rdv_log.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      rdv_t e = (i < rdv_log.size()) ? rdv_log[i] : '{cyc: 0, data: '0};
      n_checks++;
      if (e.cyc !== t0 + 3 + i || e.data !== 32'h50 + i)
        $display("FAIL b2b_beat%0d: got cyc T+%0d data %h want T+%0d data %h",
                 i, e.cyc - t0, e.data, 3 + i, 32'h50 + i);
      else n_pass++;
    end
    n_checks++;
    if (wr_log.size() != 1 || wr_log[0].a !== 19'h60 || wr_log[0].d !== 32'hBEEF)
      $display("FAIL b2b_write: got %0d writes want 1 to 0x60 data beef", wr_log.size());
    else n_pass++;
    csr_access(1'b1, CsrRdBeats, 32'h1234, q);
    csr_access(1'b0, CsrRdBeats, 32'd0, q);
    n_checks++;
    if (q !== 32'd0) $display("FAIL rdbeats_clear: got %0d want 0", q); else n_pass++;
  endtask

  initial begin
    bus.addr = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    bus.byteenable = '0; bus.burstcount = '0;
    csr_addr = '0; csr_read = 1'b0; csr_write = 1'b0; csr_wdata = '0;
    test_reset();
    test_read_burst();
    test_wrap();
    test_write_stall();
    test_errors();
    test_reset_mid_read();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
